uart_tx_fifo: RTL and testbench

- Transmit-side counterpart of the UART receive packer.
- Accepts 32-bit words of 1–4 bytes from the Wishbone/CPU side into a small word FIFO.
- Unpacks each word MSB-first (byte 0 = bits [31:24], matching the RX packing order) and hands bytes one at a time to the UART transmitter with a start/done handshake.
- Raises a sticky interrupt per completed word; a watchdog aborts a stalled transmitter.

---
 rtl/uart_tx_fifo_pkg.sv | 30 +++
 rtl/uart_tx_fifo_word_fifo.sv | 81 ++++++++
 rtl/uart_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: transmit FSM encoding, byte-count clamp and the
// default idle/abort timeout used by both the RX packer and the TX unpacker.
package uart_tx_fifo_pkg;

    localparam int DATA_W          = 32;
    localparam int NUM_W           = 3;
    localparam int TIMEOUT_DEFAULT = 60000;

    localparam logic [NUM_W-1:0] MAX_BYTES = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_IRQ       = 3'd4
    } tx_state_e;

    // Byte counts above MAX_BYTES are treated as a full word.
    function automatic logic [NUM_W-1:0] clamp_num(input logic [NUM_W-1:0] num);
        logic [NUM_W-1:0] res;
        if (num > MAX_BYTES) begin
            res = MAX_BYTES;
        end else begin
            res = num;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_word_fifo.sv
// Synchronous word FIFO holding {num, data} entries for the TX unpacker.
// Full is judged before the same-cycle pop, so a push into a full FIFO is lost.
module uart_word_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = DATA_W + NUM_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign rdata     = mem_q[rd_ptr_q];
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit unpacker: queues 1-4 byte words and feeds them MSB-first to
// the transmitter with a start/done handshake, with a watchdog on done.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr,
    input  logic [31:0]       i_tx_data,
    input  logic [2:0]        i_tx_num,
    output logic              o_ready,
    output logic [7:0]        o_tx_byte,
    output logic              o_tx_start,
    input  logic              i_tx_busy,
    input  logic              i_tx_done,
    output logic              o_irq,
    input  logic              i_irq_ack,
    output logic [31:0]       o_sent_num,
    output logic              o_ovf,
    output logic              o_tx_err,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    tx_state_e                   state_q, state_d;
    logic [DATA_W-1:0]           shreg_q, shreg_d;
    logic [NUM_W-1:0]            bytes_left_q, bytes_left_d;
    logic [NUM_W-1:0]            sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic [7:0]                  tx_byte_q, tx_byte_d;
    logic                        tx_start_q, tx_start_d;
    logic [31:0]                 sent_num_q, sent_num_d;
    logic                        irq_q, irq_d;
    logic                        ovf_q, ovf_d;
    logic                        err_q, err_d;

    logic                        pop_s;
    logic                        irq_set_s;
    logic                        err_set_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [$clog2(DEPTH):0]      fifo_count_s;
    logic [DATA_W+NUM_W-1:0]     fifo_rdata_s;
    logic [NUM_W-1:0]            pop_num_s;

    uart_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + NUM_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_wr),
        .pop   (pop_s),
        .wdata ({i_tx_num, i_tx_data}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign pop_num_s = clamp_num(fifo_rdata_s[DATA_W+NUM_W-1:DATA_W]);

    // Transmit FSM: next state, unpacking datapath and watchdog.
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bytes_left_d = bytes_left_q;
        sent_cnt_d   = sent_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        tx_byte_d    = tx_byte_q;
        tx_start_d   = 1'b0;
        sent_num_d   = sent_num_q;
        pop_s        = 1'b0;
        irq_set_s    = 1'b0;
        err_set_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s && !i_tx_busy) begin
                    pop_s        = 1'b1;
                    shreg_d      = fifo_rdata_s[DATA_W-1:0];
                    bytes_left_d = pop_num_s;
                    // An empty word is consumed silently.
                    if (pop_num_s == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                tx_byte_d  = shreg_q[31:24];
                tx_start_d = 1'b1;
                tmo_cnt_d  = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_tx_done) begin
                    shreg_d      = {shreg_q[23:0], 8'h00};
                    bytes_left_d = bytes_left_q - 3'd1;
                    sent_cnt_d   = sent_cnt_q + 3'd1;
                    if (bytes_left_q == 3'd1) begin
                        state_d = ST_IRQ;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else if (tmo_cnt_q >= TMO_LAST) begin
                    err_set_s = 1'b1;
                    state_d   = ST_IRQ;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                end
            end
            ST_IRQ: begin
                sent_num_d = {29'd0, sent_cnt_q};
                irq_set_s  = 1'b1;
                sent_cnt_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky status flags; a same-cycle set beats the acknowledge.
    always_comb begin
        irq_d = irq_set_s | (irq_q & ~i_irq_ack);
        ovf_d = (i_wr & fifo_full_s) | (ovf_q & ~i_irq_ack);
        err_d = err_set_s | (err_q & ~i_irq_ack);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bytes_left_q <= '0;
            sent_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            tx_byte_q    <= '0;
            tx_start_q   <= 1'b0;
            sent_num_q   <= '0;
            irq_q        <= 1'b0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bytes_left_q <= bytes_left_d;
            sent_cnt_q   <= sent_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tx_byte_q    <= tx_byte_d;
            tx_start_q   <= tx_start_d;
            sent_num_q   <= sent_num_d;
            irq_q        <= irq_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
        end
    end

    assign o_ready    = ~fifo_full_s;
    assign o_busy     = (state_q != ST_IDLE) | (fifo_count_s != '0);
    assign o_tx_byte  = tx_byte_q;
    assign o_tx_start = tx_start_q;
    assign o_sent_num = sent_num_q;
    assign o_irq      = irq_q;
    assign o_ovf      = ovf_q;
    assign o_tx_err   = err_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed plus randomized bench for uart_tx_fifo with a transmitter
// responder and a queue-based model of the expected byte stream.
module tb_uart_tx_fifo;

    logic        clk;
    logic        rst;
    logic        i_wr;
    logic [31:0] i_tx_data;
    logic [2:0]  i_tx_num;
    logic        o_ready;
    logic [7:0]  o_tx_byte;
    logic        o_tx_start;
    logic        i_tx_busy;
    logic        i_tx_done;
    logic        o_irq;
    logic        i_irq_ack;
    logic [31:0] o_sent_num;
    logic        o_ovf;
    logic        o_tx_err;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;

    int cyc_cnt = 0;
    logic [7:0] seen_q [$];
    int         start_cyc [$];
    logic [7:0] exp_q [$];

    int resp_delay = 10;
    int resp_n     = 0;
    int drop_at    = -1;

    uart_tx_fifo #(
        .DEPTH   (2),
        .TIMEOUT (100),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wr       (i_wr),
        .i_tx_data  (i_tx_data),
        .i_tx_num   (i_tx_num),
        .o_ready    (o_ready),
        .o_tx_byte  (o_tx_byte),
        .o_tx_start (o_tx_start),
        .i_tx_busy  (i_tx_busy),
        .i_tx_done  (i_tx_done),
        .o_irq      (o_irq),
        .i_irq_ack  (i_irq_ack),
        .o_sent_num (o_sent_num),
        .o_ovf      (o_ovf),
        .o_tx_err   (o_tx_err),
        .o_busy     (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: log every byte handed to the transmitter.
    always @(posedge clk) begin
        #1;
        cyc_cnt++;
        if (o_tx_start) begin
            seen_q.push_back(o_tx_byte);
            start_cyc.push_back(cyc_cnt);
        end
    end

    // Transmitter model: done pulse resp_delay cycles after each start.
    initial begin
        i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start) begin
                resp_n++;
                if (resp_n != drop_at) begin
                    repeat (resp_delay) @(negedge clk);
                    i_tx_done = 1'b1;
                    @(negedge clk);
                    i_tx_done = 1'b0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_word(input logic [31:0] data, input logic [2:0] num);
        i_tx_data = data;
        i_tx_num  = num;
        i_wr      = 1'b1;
        @(negedge clk);
        i_wr      = 1'b0;
    endtask

    task automatic ack_pulse();
        i_irq_ack = 1'b1;
        @(negedge clk);
        i_irq_ack = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(o_busy), 32'd0);
    endtask

    task automatic wait_starts(input int cnt, input int budget);
        int n;
        n = 0;
        while (seen_q.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(seen_q.size()), 32'(cnt));
    endtask

    // Expected bytes of a word: the first min(num,4) bytes, highest byte first.
    task automatic model_word(input logic [31:0] data, input int num);
        int n;
        logic [31:0] t;
        n = (num > 4) ? 4 : num;
        for (int i = 0; i < n; i++) begin
            t = data >> (24 - 8 * i);
            exp_q.push_back(t[7:0]);
        end
    endtask

    task automatic compare_bytes(input string tag);
        int n;
        check({tag, "_count"}, 32'(seen_q.size()), 32'(exp_q.size()));
        n = (seen_q.size() < exp_q.size()) ? seen_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_byte"}, 32'(seen_q[i]), 32'(exp_q[i]));
        end
    endtask

    task automatic clear_logs();
        seen_q.delete();
        start_cyc.delete();
        exp_q.delete();
    endtask

    initial begin
        int model_cnt;
        int t_start;
        int n;
        logic [31:0] rdata;
        int rnum;
        int clamped;

        rst = 1'b1; i_wr = 1'b0; i_tx_data = 32'd0; i_tx_num = 3'd0;
        i_tx_busy = 1'b0; i_irq_ack = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);

        // Reset state
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_start", 32'(o_tx_start), 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        check("rst_ovf", 32'(o_ovf), 32'd0);
        check("rst_err", 32'(o_tx_err), 32'd0);
        check("rst_sent", o_sent_num, 32'd0);
        check("rst_byte", 32'(o_tx_byte), 32'd0);

        // Four-byte word with first-start latency
        clear_logs();
        resp_delay = 10;
        i_tx_data = 32'hA1B2C3D4; i_tx_num = 3'd4; i_wr = 1'b1;
        @(negedge clk);
        i_wr = 1'b0;
        check("lat_k0", 32'(o_tx_start), 32'd0);
        cyc(1);
        check("lat_k1", 32'(o_tx_start), 32'd0);
        cyc(1);
        check("lat_k2", 32'(o_tx_start), 32'd1);
        check("lat_byte", 32'(o_tx_byte), 32'hA1);
        model_word(32'hA1B2C3D4, 4);
        wait_idle(300);
        compare_bytes("w4");
        check("w4_irq", 32'(o_irq), 32'd1);
        check("w4_sent", o_sent_num, 32'd4);
        ack_pulse();
        check("w4_ack", 32'(o_irq), 32'd0);

        // Two-byte word, empty word, clamped seven-byte word
        clear_logs();
        write_word(32'h55AA0000, 3'd2);
        model_word(32'h55AA0000, 2);
        wait_idle(300);
        compare_bytes("w2");
        check("w2_sent", o_sent_num, 32'd2);
        check("w2_irq", 32'(o_irq), 32'd1);
        ack_pulse();
        clear_logs();
        write_word(32'hDEADBEEF, 3'd0);
        wait_idle(50);
        cyc(5);
        check("w0_nobytes", 32'(seen_q.size()), 32'd0);
        check("w0_irq", 32'(o_irq), 32'd0);
        clear_logs();
        write_word(32'h01020304, 3'd7);
        model_word(32'h01020304, 7);
        wait_idle(300);
        compare_bytes("w7");
        check("w7_sent", o_sent_num, 32'd4);
        ack_pulse();

        // Overflow while the transmitter is busy
        clear_logs();
        i_tx_busy = 1'b1;
        model_cnt = 0;
        check("ovf_ready0", 32'(o_ready), 32'(model_cnt < 2));
        write_word(32'h11223344, 3'd2);
        model_word(32'h11223344, 2); model_cnt++;
        check("ovf_ready1", 32'(o_ready), 32'(model_cnt < 2));
        write_word(32'h55667788, 3'd3);
        model_word(32'h55667788, 3); model_cnt++;
        check("ovf_ready2", 32'(o_ready), 32'(model_cnt < 2));
        write_word(32'h99AABBCC, 3'd4);
        check("ovf_flag", 32'(o_ovf), 32'd1);
        check("ovf_busy", 32'(o_busy), 32'd1);
        cyc(5);
        check("ovf_hold", 32'(seen_q.size()), 32'd0);
        i_tx_busy = 1'b0;
        wait_idle(400);
        compare_bytes("ovf");
        check("ovf_irq", 32'(o_irq), 32'd1);
        check("ovf_sent", o_sent_num, 32'd3);
        ack_pulse();
        check("ovf_ack_irq", 32'(o_irq), 32'd0);
        check("ovf_ack_ovf", 32'(o_ovf), 32'd0);

        // Watchdog abort on the second byte
        clear_logs();
        resp_delay = 4;
        drop_at = resp_n + 2;
        write_word(32'hCAFEBABE, 3'd3);
        model_word(32'hCAFEBABE, 2);
        wait_starts(2, 200);
        t_start = (start_cyc.size() > 1) ? start_cyc[1] : cyc_cnt;
        n = 0;
        while (!o_irq && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("tmo_window", 32'((cyc_cnt - t_start) >= 97 && (cyc_cnt - t_start) <= 107), 32'd1);
        wait_idle(50);
        compare_bytes("tmo");
        check("tmo_err", 32'(o_tx_err), 32'd1);
        check("tmo_irq", 32'(o_irq), 32'd1);
        check("tmo_sent", o_sent_num, 32'd1);
        ack_pulse();
        check("tmo_ack_err", 32'(o_tx_err), 32'd0);
        drop_at = -1;
        clear_logs();
        write_word(32'h3C4D5E6F, 3'd2);
        model_word(32'h3C4D5E6F, 2);
        wait_idle(300);
        compare_bytes("post_tmo");
        check("post_tmo_sent", o_sent_num, 32'd2);
        check("post_tmo_err", 32'(o_tx_err), 32'd0);
        ack_pulse();

        // Reset during WAIT_DONE of the second byte with a word queued
        clear_logs();
        resp_delay = 20;
        write_word(32'h0A0B0C0D, 3'd4);
        write_word(32'h0E0F1011, 3'd4);
        wait_starts(2, 200);
        cyc(3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mrst_start", 32'(o_tx_start), 32'd0);
        check("mrst_busy", 32'(o_busy), 32'd0);
        check("mrst_ready", 32'(o_ready), 32'd1);
        check("mrst_irq", 32'(o_irq), 32'd0);
        check("mrst_sent", o_sent_num, 32'd0);
        cyc(60);
        check("mrst_nomore", 32'(seen_q.size()), 32'd2);
        check("mrst_idle", 32'(o_busy), 32'd0);

        // Acknowledge colliding with the IRQ state
        clear_logs();
        resp_delay = 5;
        write_word(32'h77000000, 3'd1);
        n = 0;
        while (!o_tx_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (resp_delay + 1) @(negedge clk);
        ack_pulse();
        check("ackcol_irq", 32'(o_irq), 32'd1);
        check("ackcol_sent", o_sent_num, 32'd1);
        ack_pulse();
        check("ackcol_clear", 32'(o_irq), 32'd0);
        wait_idle(50);

        // Randomized words
        for (int w = 0; w < 8; w++) begin
            clear_logs();
            resp_delay = $urandom_range(1, 12);
            rdata = $urandom;
            rnum = $urandom_range(0, 7);
            clamped = (rnum > 4) ? 4 : rnum;
            write_word(rdata, 3'(rnum));
            model_word(rdata, rnum);
            wait_idle(400);
            compare_bytes("rnd");
            if (clamped > 0) begin
                check("rnd_irq", 32'(o_irq), 32'd1);
                check("rnd_sent", o_sent_num, 32'(clamped));
            end else begin
                check("rnd_noirq", 32'(o_irq), 32'd0);
            end
            ack_pulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
